// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - funct codes, FSM state encoding and shift direction codes
package shift_pkg;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] DIR_LL = 2'd0;
    localparam logic [1:0] DIR_RL = 2'd1;
    localparam logic [1:0] DIR_RA = 2'd2;

    function automatic logic funct_valid(input logic [5:0] f);
        case (f)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
            FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // The V forms take their amount from rs; funct bit 2 marks them.
    function automatic logic funct_variable(input logic [5:0] f);
        return f[2];
    endfunction

    function automatic logic [1:0] funct_dir(input logic [5:0] f);
        case (f[1:0])
            2'b00:   return DIR_LL;
            2'b10:   return DIR_RL;
            default: return DIR_RA;
        endcase
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational shift of a value by a small amount in one direction
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 1
) (
    input  logic [DATA_W-1:0] i_value,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic [1:0]        i_dir,
    output logic [DATA_W-1:0] o_value
);

    always_comb begin
        o_value = i_value;
        case (i_dir)
            DIR_LL:  o_value = i_value << i_amt;
            DIR_RL:  o_value = i_value >> i_amt;
            DIR_RA:  o_value = DATA_W'($signed(i_value) >>> i_amt);
            default: o_value = i_value;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift controller that stalls the execute stage until done
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [5:0]        Funct,
    input  logic [4:0]        Shamt,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              Flush,
    output logic              SelShift,
    output logic              Busy,
    output logic              Stall,
    output logic              Done,
    output logic [DATA_W-1:0] Result
);

    localparam int         AMT_W  = $clog2(STEP + 1);
    localparam logic [4:0] STEP_L = 5'(STEP);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_value;
    logic [4:0]        r_remain;
    logic [1:0]        r_dir;
    logic              r_sel_shift;
    logic [DATA_W-1:0] r_result;

    logic              w_start_ok;
    logic [4:0]        w_amt;
    logic [4:0]        w_step_amt;
    logic [DATA_W-1:0] w_next;

    assign w_start_ok = (r_state == ST_IDLE) && Start && funct_valid(Funct);
    assign w_amt      = funct_variable(Funct) ? RsData[4:0] : Shamt;
    assign w_step_amt = (r_remain < STEP_L) ? r_remain : STEP_L;

    shift_step_unit #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_step (
        .i_value (r_value),
        .i_amt   (w_step_amt[AMT_W-1:0]),
        .i_dir   (r_dir),
        .o_value (w_next)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_value     <= '0;
            r_remain    <= '0;
            r_dir       <= DIR_LL;
            r_sel_shift <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok && !Flush) begin
                        r_value     <= RtData;
                        r_remain    <= w_amt;
                        r_dir       <= funct_dir(Funct);
                        r_sel_shift <= ~funct_variable(Funct);
                        if (w_amt == 5'd0) begin
                            r_state  <= ST_DONE;
                            r_result <= RtData;
                        end else begin
                            r_state  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (Flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_value  <= w_next;
                        r_remain <= r_remain - w_step_amt;
                        // Result is published on the way into DONE so it is valid there.
                        if (r_remain == w_step_amt) begin
                            r_state  <= ST_DONE;
                            r_result <= w_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SelShift = r_sel_shift;
    assign Result   = r_result;
    assign Busy     = (r_state != ST_IDLE);
    assign Stall    = !Rst && (w_start_ok || (r_state == ST_SHIFT));
    assign Done     = !Rst && !Flush && (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer at STEP=1 and STEP=4
module tb_shift_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [5:0]  Funct = 6'd0;
    logic [4:0]  Shamt = 5'd0;
    logic [31:0] RsData = 32'd0;
    logic [31:0] RtData = 32'd0;

    logic [1:0]  sel, busy, stall, done;
    logic [31:0] result [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int          m_phase [2] = '{-1, -1};
    int          m_k     [2] = '{0, 0};
    logic [31:0] m_res   [2] = '{32'd0, 32'd0};
    logic [31:0] m_fin   [2] = '{32'd0, 32'd0};
    logic        m_sel   [2] = '{1'b0, 1'b0};

    always #5 Clk = ~Clk;

    shift_sequencer #(.DATA_W(32), .STEP(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Funct(Funct), .Shamt(Shamt),
        .RsData(RsData), .RtData(RtData), .Flush(Flush),
        .SelShift(sel[0]), .Busy(busy[0]), .Stall(stall[0]), .Done(done[0]),
        .Result(result[0])
    );

    shift_sequencer #(.DATA_W(32), .STEP(4)) u_dut4 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Funct(Funct), .Shamt(Shamt),
        .RsData(RsData), .RtData(RtData), .Flush(Flush),
        .SelShift(sel[1]), .Busy(busy[1]), .Stall(stall[1]), .Done(done[1]),
        .Result(result[1])
    );

    function automatic bit is_shift(input logic [5:0] f);
        case (f)
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic bit is_var(input logic [5:0] f);
        return (f == 6'b000100) || (f == 6'b000110) || (f == 6'b000111);
    endfunction

    function automatic int op_amt(input logic [5:0] f, input logic [31:0] rs, input logic [4:0] sh);
        logic [4:0] a;
        a = is_var(f) ? rs[4:0] : sh;
        return int'(a);
    endfunction

    function automatic logic [31:0] golden(input logic [5:0] f, input logic [31:0] rs,
                                           input logic [4:0] sh, input logic [31:0] rt);
        logic [31:0] r;
        int a;
        a = op_amt(f, rs, sh);
        case (f)
            6'b000000, 6'b000100: r = rt << a;
            6'b000010, 6'b000110: r = rt >> a;
            default:              r = $signed(rt) >>> a;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Phase model: -1 idle, 1..k shifting, k+1 result cycle.
    always @(posedge Clk) begin
        for (int j = 0; j < 2; j++) begin
            int st;
            st = (j == 0) ? 1 : 4;
            if (Rst) begin
                m_phase[j] = -1;
                m_res[j]   = 32'd0;
                m_sel[j]   = 1'b0;
            end else if (m_phase[j] < 0) begin
                if (Start && is_shift(Funct) && !Flush) begin
                    m_k[j]     = (op_amt(Funct, RsData, Shamt) + st - 1) / st;
                    m_fin[j]   = golden(Funct, RsData, Shamt, RtData);
                    m_sel[j]   = !is_var(Funct);
                    m_phase[j] = 1;
                    if (m_k[j] == 0) m_res[j] = m_fin[j];
                end
            end else if (Flush || m_phase[j] == m_k[j] + 1) begin
                m_phase[j] = -1;
            end else begin
                m_phase[j]++;
                if (m_phase[j] == m_k[j] + 1) m_res[j] = m_fin[j];
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int j = 0; j < 2; j++) begin
                logic e_busy, e_stall, e_done;
                e_busy  = (m_phase[j] >= 0);
                e_stall = !Rst && ((m_phase[j] < 0 && Start && is_shift(Funct)) ||
                                   (m_phase[j] >= 1 && m_phase[j] <= m_k[j]));
                e_done  = !Rst && !Flush && (m_phase[j] == m_k[j] + 1);
                chk($sformatf("model busy[%0d] t=%0t", j, $time), 32'(busy[j]), 32'(e_busy));
                chk($sformatf("model stall[%0d] t=%0t", j, $time), 32'(stall[j]), 32'(e_stall));
                chk($sformatf("model done[%0d] t=%0t", j, $time), 32'(done[j]), 32'(e_done));
                chk($sformatf("model sel[%0d] t=%0t", j, $time), 32'(sel[j]), 32'(m_sel[j]));
                chk($sformatf("model result[%0d] t=%0t", j, $time), result[j], m_res[j]);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input int d,
                         input int exp_cyc, input logic [31:0] exp_res, input logic exp_sel);
        int c;
        bit seen;
        Funct = f; Shamt = sh; RsData = rs; RtData = rt; Start = 1'b1;
        @(negedge Clk);
        chk({name, " stall_cycle0"}, 32'(stall[d]), 32'd1);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            tick();
            Start = 1'b0;
            @(negedge Clk);
            c++;
            if (done[d]) seen = 1'b1;
        end
        chk({name, " done_cycle"}, 32'(c), 32'(exp_cyc));
        chk({name, " result"}, result[d], exp_res);
        chk({name, " selshift"}, 32'(sel[d]), 32'(exp_sel));
        c = 0;
        while (busy != 2'b00 && c < 40) begin
            tick();
            @(negedge Clk);
            c++;
        end
        chk({name, " back_to_idle"}, 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk_en = 1'b1;
        @(negedge Clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset result", result[0], 32'd0);
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        tick();
        Rst = 1'b0;
        tick();

        do_op("t1_sll4", 6'b000000, 5'd4, 32'd0, 32'h0000_0001, 0, 5, 32'h0000_0010, 1'b1);

        Funct = 6'b000010; Shamt = 5'd10; RtData = 32'hFFFF_0000; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        @(negedge Clk);
        chk("t5 flush idle", 32'(busy), 32'd0);
        chk("t5 result1 held", result[0], 32'h0000_0010);
        chk("t5 result4 held", result[1], 32'h0000_0010);
        tick();
        Funct = 6'b100000; Start = 1'b1;
        @(negedge Clk);
        chk("t5 add stall", 32'(stall), 32'd0);
        tick();
        Start = 1'b0;
        @(negedge Clk);
        chk("t5 add busy", 32'(busy), 32'd0);
        tick();

        Funct = 6'b000000; Shamt = 5'd2; Start = 1'b1; Flush = 1'b1;
        tick();
        Start = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        chk("flush_at_accept busy", 32'(busy), 32'd0);
        tick();

        do_op("t2_srav3", 6'b000111, 5'd0, 32'h0000_0023, 32'h8000_0000, 0, 4, 32'hF000_0000, 1'b0);
        do_op("t3_srl0", 6'b000010, 5'd0, 32'd0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 1'b1);
        do_op("t4_sll31", 6'b000000, 5'd31, 32'd0, 32'h0000_0001, 1, 9, 32'h8000_0000, 1'b1);
        do_op("sra7_step4", 6'b000011, 5'd7, 32'd0, 32'h8000_1234, 1, 3, 32'hFF00_0024, 1'b1);
        do_op("srlv31_step4", 6'b000110, 5'd0, 32'h0000_001F, 32'hFFFF_FFFF, 1, 9, 32'h0000_0001, 1'b0);

        Funct = 6'b000000; Shamt = 5'd20; RtData = 32'h0000_00FF; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("t6 rst busy", 32'(busy), 32'd0);
        chk("t6 rst result1", result[0], 32'd0);
        chk("t6 rst result4", result[1], 32'd0);
        chk("t6 rst sel", 32'(sel), 32'd0);
        chk("t6 rst done", 32'(done), 32'd0);
        chk("t6 rst stall", 32'(stall), 32'd0);
        tick();
        do_op("t6_sll1", 6'b000000, 5'd1, 32'd0, 32'h0000_0003, 0, 2, 32'h0000_0006, 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
